// File: rtl/pixel_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | pixel_mem_pkg : shared types and width helpers for pixel_mem_if            |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package pixel_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PF_REQ  = 3'd3,
    PF_WAIT = 3'd4
  } state_t;

  // Widest {bank,addr} key a tag can hold; narrower keys are zero-extended.
  localparam int TAG_KEY_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_KEY_W-1:0] key;
  } word_tag_t;

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int sel_w(input int pix_per_word);
    return (pix_per_word > 1) ? $clog2(pix_per_word) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_mem_if_if.sv
// +----------------------------------------------------------------------------+
// | pixel_mem_if_if : request/grant/rvalid read bus to the external pixel store|
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pixel_mem_if_if #(
  parameter int BANK_W = 1,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic                     mem_req;
  logic [BANK_W+ADDR_W-1:0] mem_addr;
  logic                     mem_gnt;
  logic                     mem_rvalid;
  logic [DATA_W-1:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/pixel_mem_if_pixel_word_buf.sv
// +----------------------------------------------------------------------------+
// | pixel_word_buf : one cached memory word with tag, hit compare and pixel mux|
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module pixel_word_buf
  import pixel_mem_pkg::*;
#(
  parameter  int PIX_W        = 4,
  parameter  int PIX_PER_WORD = 8,
  parameter  int KEY_W        = 10,
  localparam int SEL_W        = sel_w(PIX_PER_WORD),
  localparam int WORD_W       = PIX_W * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [KEY_W-1:0]  fill_key,
  input  logic [WORD_W-1:0] fill_word,
  input  logic [KEY_W-1:0]  lk_key,
  input  logic [SEL_W-1:0]  lk_sel,
  output logic              hit,
  output logic [PIX_W-1:0]  lk_pixel
);

  word_tag_t         tag_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= '0;
      word_q <= '0;
    end else if (fill) begin
      tag_q.valid <= 1'b1;
      tag_q.key   <= TAG_KEY_W'(fill_key);
      word_q      <= fill_word;
    end
  end

  assign hit      = tag_q.valid && (tag_q.key == TAG_KEY_W'(lk_key));
  assign lk_pixel = word_q[lk_sel*PIX_W +: PIX_W];

endmodule

`default_nettype wire

// File: rtl/pixel_mem_if.sv
// +----------------------------------------------------------------------------+
// | pixel_mem_if : cached per-pixel reader over a req/gnt/rvalid memory bus.   |
// | Build option PIXEL_MEM_IF_PREFETCH_EN adds a second buffer + next-word     |
// | prefetch.                                                                  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module pixel_mem_if
  import pixel_mem_pkg::*;
#(
  parameter  int PIX_W        = 4,
  parameter  int PIX_PER_WORD = 8,
  parameter  int ADDR_W       = 9,
  parameter  int NUM_BANKS    = 2,
  parameter  int MISS_CNT_W   = 16,
  localparam int BANK_W       = bank_w(NUM_BANKS),
  localparam int SEL_W        = sel_w(PIX_PER_WORD),
  localparam int KEY_W        = BANK_W + ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [BANK_W-1:0]     bank,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [SEL_W-1:0]      pix_sel,
  output logic [PIX_W-1:0]      pixel,
  output logic                  pixel_valid,
  pixel_mem_if_if.master        bus,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

`ifdef PIXEL_MEM_IF_PREFETCH_EN
  localparam int     NUM_BUF    = 2;
  localparam state_t AFTER_FILL = PF_REQ;
`else
  localparam int     NUM_BUF    = 1;
  localparam state_t AFTER_FILL = IDLE;
`endif

  state_t            state_q, state_d;
  logic              issue_req, clear_req, fill_dem, hit_out, drop, do_fill;
  logic              mem_req_q;
  logic [KEY_W-1:0]  mem_addr_q;
  logic [SEL_W-1:0]  lat_sel;
  logic [NUM_BUF-1:0] buf_fill, buf_hit;
  logic [PIX_W-1:0]  buf_pix [NUM_BUF];
  logic              any_hit;
  logic [PIX_W-1:0]  hit_pix;
  logic [KEY_W-1:0]  lk_key;

`ifdef PIXEL_MEM_IF_PREFETCH_EN
  logic              issue_pf, fill_pf, fill_ptr;
  logic [KEY_W-1:0]  pf_addr;
  assign pf_addr = {mem_addr_q[KEY_W-1:ADDR_W], mem_addr_q[ADDR_W-1:0] + ADDR_W'(1)};
  assign do_fill = fill_dem | fill_pf;

  // Fills alternate between buffers, so each fill overwrites the older word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fill_ptr <= 1'b0;
    else if (do_fill) fill_ptr <= ~fill_ptr;
  end
  assign buf_fill = do_fill ? (fill_ptr ? 2'b10 : 2'b01) : 2'b00;
`else
  assign do_fill  = fill_dem;
  assign buf_fill = do_fill;
`endif

  assign lk_key = {bank, addr};

  generate
    for (genvar i = 0; i < NUM_BUF; i++) begin : g_buf
      pixel_word_buf #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD),
        .KEY_W        (KEY_W)
      ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .fill      (buf_fill[i]),
        .fill_key  (mem_addr_q),
        .fill_word (bus.mem_rdata),
        .lk_key    (lk_key),
        .lk_sel    (pix_sel),
        .hit       (buf_hit[i]),
        .lk_pixel  (buf_pix[i])
      );
    end
  endgenerate

  always_comb begin
    any_hit = |buf_hit;
    hit_pix = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (buf_hit[i]) hit_pix = buf_pix[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue_req = 1'b0;
    clear_req = 1'b0;
    fill_dem  = 1'b0;
    hit_out   = 1'b0;
    drop      = 1'b0;
`ifdef PIXEL_MEM_IF_PREFETCH_EN
    fill_pf   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (any_hit) begin
            hit_out = 1'b1;
          end else begin
            issue_req = 1'b1;
            state_d   = REQ;
          end
        end
      end
      // Grant and data in the same cycle behave as grant then data.
      REQ: begin
        drop = req;
        if (bus.mem_gnt) begin
          clear_req = 1'b1;
          if (bus.mem_rvalid) begin
            fill_dem = 1'b1;
            state_d  = AFTER_FILL;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        drop = req;
        if (bus.mem_rvalid) begin
          fill_dem = 1'b1;
          state_d  = AFTER_FILL;
        end
      end
`ifdef PIXEL_MEM_IF_PREFETCH_EN
      PF_REQ: begin
        drop = req;
        if (bus.mem_gnt) begin
          clear_req = 1'b1;
          if (bus.mem_rvalid) begin
            fill_pf = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PF_WAIT;
          end
        end
      end
      PF_WAIT: begin
        drop = req;
        if (bus.mem_rvalid) begin
          fill_pf = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef PIXEL_MEM_IF_PREFETCH_EN
    issue_pf = fill_dem;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      lat_sel     <= '0;
      miss_cnt    <= '0;
    end else begin
      pixel_valid <= 1'b0;
      if (hit_out) begin
        pixel       <= hit_pix;
        pixel_valid <= 1'b1;
      end
      if (fill_dem) begin
        pixel       <= bus.mem_rdata[lat_sel*PIX_W +: PIX_W];
        pixel_valid <= 1'b1;
      end
      if (clear_req) mem_req_q <= 1'b0;
      if (issue_req) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= lk_key;
        lat_sel    <= pix_sel;
      end
`ifdef PIXEL_MEM_IF_PREFETCH_EN
      if (issue_pf) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= pf_addr;
      end
`endif
      if (drop && (miss_cnt != '1)) miss_cnt <= miss_cnt + MISS_CNT_W'(1);
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: doc/pixel_mem_if.md
Name: pixel_mem_if

Overview:
- Parametrised pixel memory interface between the HDMI pixel pipeline and the external pixel store.
- Accepts per-pixel requests as bank, word address and pixel select.
- Caches the last fetched word, fetches missing words over a request/grant/rvalid bus, and returns one PIX_W pixel.
- Successor to the fixed 4-bit, 2-bank, 8-pixel-per-word interface. Adds generic widths/banks, a handshake bus, miss accounting and optional prefetch.

Parameters:
- PIX_W, 4, bits per pixel
- PIX_PER_WORD, 8, pixels packed per memory word (power of two)
- ADDR_W, 9, word address bits per bank
- NUM_BANKS, 2, number of banks (≥1)
- MISS_CNT_W, 16, width of miss counter

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous active-high reset
- req  in  1  pixel request strobe, one cycle per pixel
- bank  in  max(1,$clog2(NUM_BANKS))  bank select
- addr  in  ADDR_W  word address
- pix_sel  in  $clog2(PIX_PER_WORD)  pixel index within word, 0 = LSBs
- pixel  out  PIX_W  returned pixel
- pixel_valid  out  1  pixel is valid this cycle
- mem_req  out  1  memory read request
- mem_addr  out  BANK_W+ADDR_W  {bank,addr} of request
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  PIX_W*PIX_PER_WORD  read word
- miss_cnt  out  MISS_CNT_W  saturating count of dropped requests

Behaviour:
- Reset values: pixel=0, pixel_valid=0, mem_req=0, mem_addr=0, miss_cnt=0. The word tag is invalid and the FSM is in IDLE.
- Storage is one word register plus tag {bank,addr} plus a valid bit.
- FSM states: IDLE, REQ, WAIT.
- IDLE, req, tag hit: pixel = word[pix_sel*PIX_W +: PIX_W] and pixel_valid=1 on the next cycle (latency 1).
- IDLE, req, miss: latch {bank,addr,pix_sel}, assert mem_req with mem_addr, go to REQ.
- REQ: hold mem_req and mem_addr stable until mem_gnt. mem_req drops on the cycle after the grant, then go to WAIT. If mem_gnt and mem_rvalid arrive together, treat them as grant followed by data.
- WAIT: on mem_rvalid, write word and tag, set valid, and output the latched pix_sel pixel with pixel_valid=1 next cycle. Return to IDLE.
- req in REQ/WAIT, including the cycle mem_rvalid is seen: the request is dropped. miss_cnt increments and saturates at all-ones. pixel holds its last value and pixel_valid=0.
- pixel_valid is a one-cycle pulse per serviced request. pixel holds its value between pulses.
- mem_rvalid in IDLE is ignored. This covers stale data returned after a reset taken mid-fetch.
- Async reset in any state returns to IDLE immediately and invalidates the tag.
- Bank and address values are used as given, with no range check.

Optional Feature:
- Macro PIXEL_MEM_IF_PREFETCH_EN.
- Defined: adds a second word/tag buffer. After each demand fill, the block issues a fetch for {bank, addr+1}. addr wraps from 2^ADDR_W-1 to 0 within the same bank.
- Prefetch uses states PF_REQ/PF_WAIT. A demand req arriving during a prefetch is dropped and counted. Hits are checked against both buffers. Each fill replaces the older buffer.
- Not defined: single buffer, no speculative traffic.

Decomposition:
- Package pixel_mem_pkg holds the FSM state enum (IDLE, REQ, WAIT, PF_REQ, PF_WAIT), the BANK_W/SEL_W localparam functions and a word-tag struct type.
- One natural sub-module is pixel_word_buf: word register, tag, valid bit, hit compare and pix_sel mux. It is instantiated once, or twice with prefetch enabled.

Test Plan:
- Reset, then req bank=0 addr=5 sel=3. Expect mem_req with mem_addr=0x005. Respond gnt, then rvalid with rdata=0x76543210. Expect pixel=3 with pixel_valid=1 one cycle after rvalid.
- Follow-up req addr=5 sel=7. Expect pixel=7 one cycle later and no mem_req (hit).
- Miss on bank=1 addr=0x1FF, then req on every cycle during WAIT, including the rvalid cycle. Expect miss_cnt to count the dropped reqs exactly and mem_addr=0x3FF.
- Hold mem_gnt low for 10 cycles. Expect mem_req and mem_addr stable throughout, then mem_req low on the cycle after the grant.
- Assert rst during WAIT, then drive mem_rvalid. Expect all outputs at reset values, no pixel_valid, and the tag invalid (the next req to the same address misses).
- With PIXEL_MEM_IF_PREFETCH_EN: after a fill at addr=0x1FF, expect a prefetch to addr 0x000 in the same bank. A later req to 0x000 then hits with latency 1.
